nios_dbg_ocimem_ctrl: RTL

Debug-side on-chip memory controller placed directly downstream of the Nios II JTAG debug slave sysclk stage. It consumes the synchronised JTAG data word and `take_action_ocimem_*` strobes, performs single-word reads and writes into a local debug RAM with address auto-increment, and returns the results as `MonDReg`, `monitor_ready` and `monitor_error` to the debug slave's TCK-side capture path. An optional CPU-side slave port shares the same RAM under fixed debug-priority arbitration.

---
 rtl/nios_dbg_pkg.sv | 17 +
 rtl/nios_dbg_ocimem_ram.sv | 24 ++
 rtl/nios_dbg_ocimem_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/nios_dbg_pkg.sv
// Shared definitions for the Nios II debug on-chip memory controller:
// FSM state encoding and the field positions inside the 38-bit jdo word.
package nios_dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ADDR = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR      = 2'd3
  } ocimem_state_e;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_CLR_BIT   = 36;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios_dbg_ocimem_ram.sv
// Single-port 2**ADDR_W x 32 debug RAM, synchronous read with one cycle of
// latency, read-before-write on a same-address access.
module nios_dbg_ocimem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [2**ADDR_W];

  // NOTE: the array has no reset; clearing a memory would need a per-word
  // sequencer and would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/nios_dbg_ocimem_ctrl.sv
// Debug-side OCI memory controller: JTAG address-set / read-next / write
// commands into a local RAM. Optional CPU slave port: NIOS_OCIMEM_CPU_PORT_EN.
module nios_dbg_ocimem_ctrl
  import nios_dbg_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_writedata,
  output logic [31:0]       cpu_readdata,
  output logic              cpu_readdatavalid,
  output logic              cpu_waitrequest
);

  ocimem_state_e     state_q;
  logic [ADDR_W-1:0] dbg_addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mon_dreg_q;
  logic              ready_q;
  logic              error_q;

  logic              idle;
  logic              any_strobe;
  logic              multi_strobe;
  logic              acc_a;
  logic              acc_n;
  logic              acc_b;
  logic              strobe_err;
  logic [ADDR_W-1:0] jdo_addr;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic              unused_ok;

  assign idle         = (state_q == ST_IDLE);
  assign any_strobe   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign multi_strobe = (take_action_ocimem_b & take_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a)
                      | (take_action_ocimem_a & take_no_action_ocimem_a);
  // Only one command is accepted per cycle; b outranks a, a outranks read-next.
  assign acc_b        = idle & take_action_ocimem_b;
  assign acc_a        = idle & take_action_ocimem_a & ~take_action_ocimem_b;
  assign acc_n        = idle & take_no_action_ocimem_a & ~take_action_ocimem_a
                      & ~take_action_ocimem_b;
  assign strobe_err   = any_strobe & (~idle | multi_strobe);
  assign jdo_addr     = jdo[JDO_ADDR_LSB +: ADDR_W];

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      dbg_addr_q <= '0;
      wdata_q    <= '0;
      mon_dreg_q <= '0;
      ready_q    <= 1'b1;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc_b) begin
            wdata_q <= jdo[JDO_WDATA_LSB +: 32];
            state_q <= ST_WR;
            ready_q <= 1'b0;
          end else if (acc_a) begin
            dbg_addr_q <= jdo_addr;
            if (jdo[JDO_RD_BIT]) begin
              state_q <= ST_RD_ADDR;
              ready_q <= 1'b0;
            end
          end else if (acc_n) begin
            state_q <= ST_RD_ADDR;
            ready_q <= 1'b0;
          end
        end
        ST_RD_ADDR: state_q <= ST_RD_DATA;
        ST_RD_DATA: begin
          mon_dreg_q <= ram_rdata;
          dbg_addr_q <= dbg_addr_q + 1'b1;
          state_q    <= ST_IDLE;
          ready_q    <= 1'b1;
        end
        ST_WR: begin
          dbg_addr_q <= dbg_addr_q + 1'b1;
          state_q    <= ST_IDLE;
          ready_q    <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase

      // A dropped strobe in the same cycle outweighs a requested clear.
      if (strobe_err) begin
        error_q <= 1'b1;
      end else if (acc_a && jdo[JDO_CLR_BIT]) begin
        error_q <= 1'b0;
      end
    end
  end

  assign MonDReg       = mon_dreg_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

`ifdef NIOS_OCIMEM_CPU_PORT_EN
  logic cpu_wait;
  logic cpu_rd_acc;
  logic cpu_wr_acc;
  logic cpu_rvalid_q;

  assign cpu_wait   = ~idle | any_strobe;
  assign cpu_rd_acc = cpu_read & ~cpu_wait;
  assign cpu_wr_acc = cpu_write & ~cpu_wait;

  // The CPU owns the RAM port only while the debug FSM is idle.
  assign ram_we    = (state_q == ST_WR) | cpu_wr_acc;
  assign ram_addr  = idle ? cpu_address : dbg_addr_q;
  assign ram_wdata = idle ? cpu_writedata : wdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid_q <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_rd_acc;
    end
  end

  assign cpu_readdata      = cpu_rvalid_q ? ram_rdata : '0;
  assign cpu_readdatavalid = cpu_rvalid_q;
  assign cpu_waitrequest   = cpu_wait;
  assign unused_ok         = ^{jdo[37], jdo[2:0]};
`else
  assign ram_we            = (state_q == ST_WR);
  assign ram_addr          = dbg_addr_q;
  assign ram_wdata         = wdata_q;
  assign cpu_readdata      = '0;
  assign cpu_readdatavalid = 1'b0;
  assign cpu_waitrequest   = 1'b0;
  assign unused_ok         = ^{jdo[37], jdo[2:0], cpu_address, cpu_read, cpu_write,
                               cpu_writedata};
`endif

  nios_dbg_ocimem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

endmodule
